// File: rtl/axi_reg_arbiter.sv
// axi_reg_arbiter: two-requester round-robin arbiter and sequencer in front of a
// single-beat AXI register slave. Commands are serialised with one transaction in
// flight, and each command gets exactly one response back to the requester that
// issued it.
//
// Ports:
//   clk, areset            clock, asynchronous active-high reset
//   req_*_i / req_ready_o  per-requester command interface (bit/slice i = requester i)
//   rsp_valid_o            per-requester response pulse; rsp_rdata_o / rsp_resp_o shared
//   aw*/w*/b*/ar*/r*       AXI master port (IDs fixed at 0, single-beat bursts)
//
// Optional feature: define ARB_TIMEOUT_EN to enable a watchdog that abandons a
// transaction stuck for TIMEOUT cycles in one state and responds with SLVERR (2'b10).
module axi_reg_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic [1:0]                  req_valid_i,
    input  logic [1:0]                  req_we_i,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [2*(DATA_WIDTH/8)-1:0] req_wstrb_i,
    output logic [1:0]                  req_ready_o,
    output logic [1:0]                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
    output logic [1:0]                  rsp_resp_o,
    output logic [3:0]                  awid_o,
    output logic [ADDR_WIDTH-1:0]       awaddr_o,
    output logic                        awvalid_o,
    input  logic                        awready_i,
    output logic [3:0]                  wid_o,
    output logic [DATA_WIDTH-1:0]       wdata_o,
    output logic [DATA_WIDTH/8-1:0]     wstrb_o,
    output logic                        wlast_o,
    output logic                        wvalid_o,
    input  logic                        wready_i,
    input  logic [3:0]                  bid_i,
    input  logic [1:0]                  bresp_i,
    input  logic                        bvalid_i,
    output logic                        bready_o,
    output logic [3:0]                  arid_o,
    output logic [ADDR_WIDTH-1:0]       araddr_o,
    output logic                        arvalid_o,
    input  logic                        arready_i,
    input  logic [3:0]                  rid_i,
    input  logic [DATA_WIDTH-1:0]       rdata_i,
    input  logic                        rlast_i,
    input  logic                        rvalid_i,
    output logic                        rready_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle, StWr, StWrResp, StRdAddr, StRdData, StDone
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_q, grant_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic [1:0]              req_ready_q, req_ready_d;
    logic                    grant_sel;
    logic                    aw_fin, w_fin;
    logic                    timeout;

    // IDs, burst info and requester-side response metadata are unused by this block.
    logic unused_inputs;
    assign unused_inputs = ^{bid_i, rid_i, rlast_i};

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy;

    assign busy    = (state_q == StWr) || (state_q == StWrResp) ||
                     (state_q == StRdAddr) || (state_q == StRdData);
    // cnt_q is 0 in the first cycle of a state, so the limit is hit in cycle TIMEOUT.
    assign timeout = busy && (cnt_q == CntW'(TIMEOUT - 1));
    assign cnt_d   = ((state_d != state_q) || !busy) ? '0 : cnt_q + CntW'(1);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout        = 1'b0;
`endif

    assign awvalid_o = (state_q == StWr) && !aw_done_q;
    assign wvalid_o  = (state_q == StWr) && !w_done_q;
    assign bready_o  = (state_q == StWrResp);
    assign arvalid_o = (state_q == StRdAddr);
    assign rready_o  = (state_q == StRdData);

    assign aw_fin = aw_done_q || (awvalid_o && awready_i);
    assign w_fin  = w_done_q || (wvalid_o && wready_i);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        req_ready_d  = 2'b00;
        grant_sel    = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid_i != 2'b00) begin
                    // On contention the requester not served last wins.
                    grant_sel    = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
                    grant_d      = grant_sel;
                    last_grant_d = grant_sel;
                    we_d         = req_we_i[grant_sel];
                    addr_d       = grant_sel ? req_addr_i[ADDR_WIDTH +: ADDR_WIDTH]
                                             : req_addr_i[0 +: ADDR_WIDTH];
                    wdata_d      = grant_sel ? req_wdata_i[DATA_WIDTH +: DATA_WIDTH]
                                             : req_wdata_i[0 +: DATA_WIDTH];
                    wstrb_d      = grant_sel ? req_wstrb_i[STRB_WIDTH +: STRB_WIDTH]
                                             : req_wstrb_i[0 +: STRB_WIDTH];
                    req_ready_d  = grant_sel ? 2'b10 : 2'b01;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = req_we_i[grant_sel] ? StWr : StRdAddr;
                end
            end
            StWr: begin
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) begin
                    state_d = StWrResp;
                end else if (timeout) begin
                    resp_d  = 2'b10;
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StWrResp: begin
                if (bvalid_i) begin
                    resp_d  = bresp_i;
                    rdata_d = '0;
                    state_d = StDone;
                end else if (timeout) begin
                    resp_d  = 2'b10;
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StRdAddr: begin
                if (arready_i) begin
                    state_d = StRdData;
                end else if (timeout) begin
                    resp_d  = 2'b10;
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StRdData: begin
                if (rvalid_i) begin
                    rdata_d = rdata_i;
                    resp_d  = 2'b00; // slave has no RRESP
                    state_d = StDone;
                end else if (timeout) begin
                    resp_d  = 2'b10;
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
            req_ready_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = (state_q == StDone) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata_o = rdata_q;
    assign rsp_resp_o  = resp_q;

    assign awid_o   = 4'd0;
    assign wid_o    = 4'd0;
    assign arid_o   = 4'd0;
    assign wlast_o  = 1'b1;
    assign awaddr_o = addr_q;
    assign araddr_o = addr_q;
    assign wdata_o  = wdata_q;
    assign wstrb_o  = wstrb_q;

endmodule

// File: tb/tb_axi_reg_arbiter.sv
module tb_axi_reg_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    localparam int ModeRandom = 0;
    localparam int ModeReady  = 1;
    localparam int ModeSkew   = 2;
    localparam int ModeHoldB  = 3;
    localparam int ModeNoAr   = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    // Requester-side drive variables
    logic        r_valid [2];
    logic        r_we    [2];
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_strb  [2];

    logic [1:0]      req_valid_i, req_we_i, req_ready_o, rsp_valid_o, rsp_resp_o;
    logic [2*AW-1:0] req_addr_i;
    logic [2*DW-1:0] req_wdata_i;
    logic [2*SW-1:0] req_wstrb_i;
    logic [DW-1:0]   rsp_rdata_o, wdata_o, rdata_i;
    logic [3:0]      awid_o, wid_o, arid_o, bid_i, rid_i;
    logic [AW-1:0]   awaddr_o, araddr_o;
    logic [SW-1:0]   wstrb_o;
    logic            awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic [1:0]      bresp_i;
    logic            bvalid_i, bready_o, arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

    assign req_valid_i = {r_valid[1], r_valid[0]};
    assign req_we_i    = {r_we[1], r_we[0]};
    assign req_addr_i  = {r_addr[1], r_addr[0]};
    assign req_wdata_i = {r_wdata[1], r_wdata[0]};
    assign req_wstrb_i = {r_strb[1], r_strb[0]};
    assign bid_i   = 4'h5;
    assign rid_i   = 4'h9;
    assign rlast_i = 1'b1;

    axi_reg_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .areset(areset),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural reference: word memory with byte strobes, write response by address rule.
    logic [31:0] ref_mem   [8];
    logic [31:0] slave_mem [8];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Environment rule: the slave answers SLVERR for word 7.
    function automatic logic [1:0] write_resp(input logic [31:0] a);
        return (a[2:0] == 3'd7) ? 2'b10 : 2'b00;
    endfunction

    rsp_t        exp_q0 [$];
    rsp_t        exp_q1 [$];
    logic [31:0] aw_log [$];
    int          grant_log [$];
    logic [1:0]  prev_valid = 2'b00;
    logic        model_last = 1'b1;
    bit          expect_timeout = 1'b0;
    logic [31:0] cur_addr, cur_wdata;
    int          aw_cycles, w_cycles, ar_cycles, rsp_count = 0;
    int          slave_mode = ModeReady;

    // Monitor / scoreboard
    initial begin
        rsp_t e;
        int   sz;
        bit   g;
        forever begin
            @(negedge clk);
            if (areset) begin
                exp_q0.delete();
                exp_q1.delete();
                model_last = 1'b1;
                prev_valid = 2'b00;
            end else begin
                if (rsp_valid_o != 2'b00) begin
                    check("rsp_onehot", $countones(rsp_valid_o), 1);
                    rsp_count++;
                    for (int i = 0; i < 2; i++) begin
                        if (rsp_valid_o[i]) begin
                            sz = (i == 0) ? exp_q0.size() : exp_q1.size();
                            check("rsp_expected", sz != 0, 1);
                            if (sz != 0) begin
                                if (i == 0) e = exp_q0.pop_front();
                                else        e = exp_q1.pop_front();
                                check("rsp_rdata", rsp_rdata_o, e.rdata);
                                check("rsp_resp", rsp_resp_o, e.resp);
                            end
                        end
                    end
                end
                if (req_ready_o != 2'b00) begin
                    check("grant_had_request", prev_valid != 2'b00, 1);
                    g = (prev_valid == 2'b11) ? ~model_last : prev_valid[1];
                    check("grant", req_ready_o, g ? 2'b10 : 2'b01);
                    grant_log.push_back(int'(g));
                    model_last = g;
                    cur_addr   = r_addr[g];
                    cur_wdata  = r_wdata[g];
                    if (expect_timeout) begin
                        e.rdata = 32'h0;
                        e.resp  = 2'b10;
                    end else if (r_we[g]) begin
                        ref_mem[r_addr[g][2:0]] = merge(ref_mem[r_addr[g][2:0]], r_wdata[g],
                                                        r_strb[g]);
                        e.rdata = 32'h0;
                        e.resp  = write_resp(r_addr[g]);
                    end else begin
                        e.rdata = ref_mem[r_addr[g][2:0]];
                        e.resp  = 2'b00;
                    end
                    if (g) exp_q1.push_back(e);
                    else   exp_q0.push_back(e);
                    aw_cycles = 0;
                    w_cycles  = 0;
                    ar_cycles = 0;
                    if (r_we[g]) check("aw_w_valid_on_accept", {awvalid_o, wvalid_o}, 2'b11);
                    else         check("ar_valid_on_accept", arvalid_o, 1'b1);
                end
                if (awvalid_o) begin
                    aw_cycles++;
                    check("awaddr", awaddr_o, cur_addr);
                    if (awready_i) aw_log.push_back(awaddr_o);
                end
                if (wvalid_o) begin
                    w_cycles++;
                    check("wdata", wdata_o, cur_wdata);
                end
                if (arvalid_o) begin
                    ar_cycles++;
                    check("araddr", araddr_o, cur_addr);
                end
                prev_valid = req_valid_i;
            end
        end
    end

    // AXI slave model: inputs are driven 1 time unit after the rising edge.
    initial begin
        bit          aw_got, w_got, b_wait, r_pend, b_hs, r_hs;
        int          aw_seen, b_delay, r_delay;
        logic [31:0] s_addr, s_data, s_raddr;
        logic [3:0]  s_strb;
        aw_got = 0; w_got = 0; b_wait = 0; r_pend = 0; b_hs = 0; r_hs = 0; aw_seen = 0;
        b_delay = 0; r_delay = 0; s_addr = 0; s_data = 0; s_raddr = 0; s_strb = 0;
        awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
        arready_i = 0; rvalid_i = 0; rdata_i = 0;
        forever begin
            @(negedge clk);
            if (areset) begin
                aw_got = 0; w_got = 0; b_wait = 0; r_pend = 0; b_hs = 0; r_hs = 0; aw_seen = 0;
            end else begin
                b_hs = bvalid_i && bready_o;
                r_hs = rvalid_i && rready_o;
                if (awvalid_o && awready_i) begin
                    aw_got = 1; s_addr = awaddr_o; aw_seen = 0;
                end else if (awvalid_o) begin
                    aw_seen++;
                end
                if (wvalid_o && wready_i) begin
                    w_got = 1; s_data = wdata_o; s_strb = wstrb_o;
                end
                if (arvalid_o && arready_i) begin
                    r_pend  = 1;
                    s_raddr = araddr_o;
                    r_delay = (slave_mode == ModeRandom) ? $urandom_range(0, 2) : 0;
                end
            end
            @(posedge clk);
            #1;
            if (areset) begin
                awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0; rvalid_i = 0;
                continue;
            end
            if (b_hs) bvalid_i = 0;
            if (r_hs) rvalid_i = 0;
            if (aw_got && w_got) begin
                slave_mem[s_addr[2:0]] = merge(slave_mem[s_addr[2:0]], s_data, s_strb);
                aw_got  = 0;
                w_got   = 0;
                b_wait  = 1;
                b_delay = (slave_mode == ModeRandom) ? $urandom_range(0, 2) : 0;
            end
            if (b_wait && slave_mode != ModeHoldB) begin
                if (b_delay == 0) begin
                    bvalid_i = 1; bresp_i = write_resp(s_addr); b_wait = 0;
                end else begin
                    b_delay--;
                end
            end
            if (r_pend) begin
                if (r_delay == 0) begin
                    rvalid_i = 1; rdata_i = slave_mem[s_raddr[2:0]]; r_pend = 0;
                end else begin
                    r_delay--;
                end
            end
            case (slave_mode)
                ModeRandom: begin
                    awready_i = 1'($urandom_range(0, 1));
                    wready_i  = 1'($urandom_range(0, 1));
                    arready_i = 1'($urandom_range(0, 1));
                end
                ModeSkew: begin
                    awready_i = (aw_seen >= 2);
                    wready_i  = 1;
                    arready_i = 1;
                end
                ModeNoAr: begin
                    awready_i = 1; wready_i = 1; arready_i = 0;
                end
                default: begin
                    awready_i = 1; wready_i = 1; arready_i = 1;
                end
            endcase
        end
    end

    task automatic issue(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        bit ok;
        @(posedge clk);
        #1;
        r_we[i] = we; r_addr[i] = addr; r_wdata[i] = data; r_strb[i] = strb;
        r_valid[i] = 1'b1;
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (req_ready_o[i]) begin
                ok = 1;
                break;
            end
        end
        check("accept", ok, 1);
        @(posedge clk);
        #1;
        r_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && req_valid_i == 2'b00) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {req_ready_o, rsp_valid_o, awvalid_o, wvalid_o, bready_o,
                               arvalid_o, rready_o}, 0);
        check({tag, "_rdata"}, rsp_rdata_o, 0);
        check({tag, "_resp"}, rsp_resp_o, 0);
        check({tag, "_addr"}, {awaddr_o, araddr_o}, 0);
        check({tag, "_wpayload"}, {wdata_o, wstrb_o}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        areset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_valid[i] = 0; r_we[i] = 0; r_addr[i] = 0; r_wdata[i] = 0; r_strb[i] = 0;
        end
        for (int a = 0; a < 8; a++) begin
            ref_mem[a]   = 32'hA5A5_0000 | (32'(a) * 32'h111);
            slave_mem[a] = ref_mem[a];
        end
        ref_mem[5]   = 32'h1234_5678;
        slave_mem[5] = 32'h1234_5678;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("const_ids_wlast", {awid_o, wid_o, arid_o, wlast_o}, 13'h1);
        @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // Single write then single read
        slave_mode = ModeReady;
        issue(0, 1'b1, 32'd3, 32'hDEAD_BEEF, 4'hF);
        wait_idle("drain_single_write");
        check("single_write_aw_beats", aw_cycles, 1);
        issue(1, 1'b0, 32'd5, 32'h0, 4'h0);
        wait_idle("drain_single_read");

        // Contention: both requesters continuously requesting
        aw_log.delete();
        grant_log.delete();
        fork
            begin
                issue(0, 1'b1, 32'd1, 32'h1111_0001, 4'hF);
                issue(0, 1'b1, 32'd1, 32'h1111_0002, 4'h3);
            end
            begin
                issue(1, 1'b1, 32'd2, 32'h2222_0001, 4'hF);
                issue(1, 1'b1, 32'd2, 32'h2222_0002, 4'hC);
            end
        join
        wait_idle("drain_contention");
        check("contention_count", aw_log.size(), 4);
        if (aw_log.size() == 4) begin
            check("contention_aw0", aw_log[0], 1);
            check("contention_aw1", aw_log[1], 2);
            check("contention_aw2", aw_log[2], 1);
            check("contention_aw3", aw_log[3], 2);
        end

        // Skewed AW/W handshakes
        slave_mode = ModeSkew;
        base = rsp_count;
        issue(0, 1'b1, 32'd4, 32'hCAFE_F00D, 4'hF);
        wait_idle("drain_skew");
        check("skew_aw_cycles", aw_cycles, 3);
        check("skew_w_cycles", w_cycles, 1);
        check("skew_rsp_count", rsp_count - base, 1);

        // Randomised traffic from both requesters
        slave_mode = ModeRandom;
        fork
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                issue(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom,
                      4'($urandom_range(0, 15)));
            end
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                issue(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom,
                      4'($urandom_range(0, 15)));
            end
        join
        wait_idle("drain_random");

        // Read whose address is never accepted
        slave_mode = ModeNoAr;
`ifdef ARB_TIMEOUT_EN
        expect_timeout = 1'b1;
        issue(0, 1'b0, 32'd2, 32'h0, 4'h0);
        wait_idle("drain_timeout");
        expect_timeout = 1'b0;
        check("timeout_ar_cycles", ar_cycles, TO);
`else
        issue(0, 1'b0, 32'd2, 32'h0, 4'h0);
        repeat (40) @(negedge clk);
        check("arvalid_held", arvalid_o, 1'b1);
        slave_mode = ModeReady;
        wait_idle("drain_stalled_read");
`endif

        // Reset while waiting for the write response
        slave_mode = ModeHoldB;
        base = rsp_count;
        issue(1, 1'b1, 32'd6, 32'h0BAD_0BAD, 4'hF);
        begin
            bit ok;
            ok = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (bready_o) begin
                    ok = 1;
                    break;
                end
            end
            check("reached_wr_resp", ok, 1);
        end
        @(posedge clk);
        #1 areset = 1'b1;
        @(negedge clk);
        check_outputs_zero("midop_reset");
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        check("no_rsp_after_reset", rsp_count - base, 0);
        slave_mode = ModeReady;
        grant_log.delete();
        fork
            issue(1, 1'b1, 32'd1, 32'h5555_0001, 4'hF);
            issue(0, 1'b1, 32'd2, 32'h5555_0002, 4'hF);
        join
        wait_idle("drain_after_reset");
        check("post_reset_grants", grant_log.size(), 2);
        if (grant_log.size() > 0) check("first_grant_after_reset", grant_log[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
